// File: rtl/pwr_seq_pkg.sv
// rtl/pwr_seq_pkg.sv - shared state encoding and parameter defaults for the WIB power sequencer
package pwr_seq_pkg;

  localparam int N_CH_DEF    = 6;
  localparam int DLY_W_DEF   = 16;
  localparam int BLINK_W_DEF = 24;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UP_3V3 = 3'd1;
  localparam logic [2:0] ST_UP_2V5 = 3'd2;
  localparam logic [2:0] ST_UP_CH  = 3'd3;
  localparam logic [2:0] ST_ON     = 3'd4;
  localparam logic [2:0] ST_DN_CH  = 3'd5;
  localparam logic [2:0] ST_DN_2V5 = 3'd6;
  localparam logic [2:0] ST_DN_3V3 = 3'd7;

endpackage

// File: rtl/seq_step_timer.sv
// rtl/seq_step_timer.sv - reloadable step countdown, pulses once max(dly,1) cycles after each load
module seq_step_timer
  import pwr_seq_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk_axi,
  input  logic             rst_n_in,
  input  logic             load_in,
  input  logic [DLY_W-1:0] dly_in,
  output logic             step_out
);

  localparam logic [DLY_W-1:0] ONE = DLY_W'(1);

  logic [DLY_W-1:0] r_cnt;
  logic [DLY_W-1:0] w_ld_val;

  // A zero delay is treated as one so the count never starts at zero and never wraps.
  assign w_ld_val = (dly_in == '0) ? ONE : dly_in;
  assign step_out = (r_cnt == ONE);

  always_ff @(posedge clk_axi or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (load_in) begin
      r_cnt <= w_ld_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/wib_pwr_seq.sv
// rtl/wib_pwr_seq.sv - ordered power-up/down of local rails and WIB channels with fault shutdown
module wib_pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DLY_W   = DLY_W_DEF,
  parameter int BLINK_W = BLINK_W_DEF
) (
  input  logic              clk_axi,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [N_CH-1:0]   en_req_in,
  input  logic [DLY_W-1:0]  dly_in,
  input  logic [N_CH-1:0]   fault_in,
  output logic              local_3v3_en_out,
  output logic              local_2v5_en_out,
  output logic [N_CH-1:0]   wib_en_out,
  output logic [N_CH-1:0]   wib_on_led_out,
  output logic [N_CH-1:0]   fault_latched_out,
  output logic              busy_out,
  output logic [2:0]        state_out
);

  localparam logic [N_CH-1:0] CH_ONE = N_CH'(1);

  logic [2:0]         r_state;
  logic [N_CH-1:0]    r_target;
  logic [N_CH-1:0]    r_wib_en;
  logic [N_CH-1:0]    r_flt;
  logic               r_3v3;
  logic               r_2v5;
  logic [BLINK_W-1:0] r_blink;

  logic               w_step;
  logic               w_load;
  logic               w_in_dn;
  logic [N_CH-1:0]    w_fault_hit;
  logic [N_CH-1:0]    w_en_nf;
  logic [N_CH-1:0]    w_pend;
  logic [N_CH-1:0]    w_lo;
  logic [N_CH-1:0]    w_hi;
  logic [2:0]         w_nxt_state;
  logic [N_CH-1:0]    w_nxt_target;
  logic [N_CH-1:0]    w_nxt_en;
  logic [N_CH-1:0]    w_nxt_flt;
  logic               w_nxt_3v3;
  logic               w_nxt_2v5;

  seq_step_timer #(.DLY_W(DLY_W)) u_step (
    .clk_axi  (clk_axi),
    .rst_n_in (rst_n_in),
    .load_in  (w_load),
    .dly_in   (dly_in),
    .step_out (w_step)
  );

  assign w_fault_hit = fault_in & r_wib_en;
  assign w_en_nf     = r_wib_en & ~w_fault_hit;
  assign w_pend      = r_target & ~r_wib_en;
  assign w_lo        = w_pend & (~w_pend + CH_ONE);
  assign w_in_dn     = (r_state == ST_DN_CH) || (r_state == ST_DN_2V5) || (r_state == ST_DN_3V3);

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_en_nf[i]) begin
        w_hi    = '0;
        w_hi[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_target = r_target;
    w_nxt_en     = w_en_nf;
    w_nxt_flt    = r_flt | w_fault_hit;
    w_nxt_3v3    = r_3v3;
    w_nxt_2v5    = r_2v5;
    w_load       = 1'b0;
    // Faulted channels are already dropped via w_en_nf; this only redirects the FSM.
    if ((|w_fault_hit) && !w_in_dn) begin
      w_nxt_state = ST_DN_CH;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            w_nxt_flt = '0;
            if (|en_req_in) begin
              w_nxt_target = en_req_in;
              w_nxt_3v3    = 1'b1;
              w_nxt_state  = ST_UP_3V3;
              w_load       = 1'b1;
            end
          end
        end
        ST_UP_3V3: begin
          if (w_step) begin
            w_nxt_2v5   = 1'b1;
            w_nxt_state = ST_UP_2V5;
            w_load      = 1'b1;
          end
        end
        ST_UP_2V5, ST_UP_CH: begin
          if (w_step) begin
            w_nxt_en = w_en_nf | w_lo;
            if (w_pend == w_lo) begin
              w_nxt_state = ST_ON;
            end else begin
              w_nxt_state = ST_UP_CH;
              w_load      = 1'b1;
            end
          end
        end
        ST_ON: begin
          if (start_in && (en_req_in == '0)) begin
            w_nxt_state = ST_DN_CH;
            w_load      = 1'b1;
          end
        end
        ST_DN_CH: begin
          // With every channel already lost to faults, the rail drop takes this step.
          if (w_step) begin
            w_load = 1'b1;
            if (|w_en_nf) begin
              w_nxt_en = w_en_nf & ~w_hi;
              if (w_en_nf == w_hi) w_nxt_state = ST_DN_2V5;
            end else begin
              w_nxt_2v5   = 1'b0;
              w_nxt_state = ST_DN_3V3;
            end
          end
        end
        ST_DN_2V5: begin
          if (w_step) begin
            w_nxt_2v5   = 1'b0;
            w_nxt_state = ST_DN_3V3;
            w_load      = 1'b1;
          end
        end
        ST_DN_3V3: begin
          if (w_step) begin
            w_nxt_3v3   = 1'b0;
            w_nxt_state = ST_IDLE;
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_axi or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_wib_en <= '0;
      r_flt    <= '0;
      r_3v3    <= 1'b0;
      r_2v5    <= 1'b0;
      r_blink  <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_target <= w_nxt_target;
      r_wib_en <= w_nxt_en;
      r_flt    <= w_nxt_flt;
      r_3v3    <= w_nxt_3v3;
      r_2v5    <= w_nxt_2v5;
      r_blink  <= r_blink + 1'b1;
    end
  end

  assign local_3v3_en_out  = r_3v3;
  assign local_2v5_en_out  = r_2v5;
  assign wib_en_out        = r_wib_en;
  assign fault_latched_out = r_flt;
  assign wib_on_led_out    = r_wib_en | (r_flt & {N_CH{r_blink[BLINK_W-1]}});
  assign busy_out          = (r_state != ST_IDLE) && (r_state != ST_ON);
  assign state_out         = r_state;

endmodule

// File: tb/tb_wib_pwr_seq.sv
// tb/tb_wib_pwr_seq.sv - directed vector and sequence bench for wib_pwr_seq
module tb_wib_pwr_seq;
  import pwr_seq_pkg::*;

  logic        clk_axi = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [5:0]  en_req_in = '0;
  logic [15:0] dly_in = '0;
  logic [5:0]  fault_in = '0;
  logic        local_3v3_en_out, local_2v5_en_out, busy_out;
  logic [5:0]  wib_en_out, wib_on_led_out, fault_latched_out;
  logic [2:0]  state_out;

  int tot = 0;
  int bad = 0;
  int blink_m = 0;

  typedef struct {
    logic        start;
    logic [5:0]  req;
    logic [5:0]  flt;
    logic [17:0] exp;
    logic [5:0]  led;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [17:0] exp;
  } cp_t;

  vec_t vt[12];
  cp_t  cps[12];

  always #5 clk_axi = ~clk_axi;

  wib_pwr_seq #(.N_CH(6), .DLY_W(16), .BLINK_W(4)) dut (
    .clk_axi           (clk_axi),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .en_req_in         (en_req_in),
    .dly_in            (dly_in),
    .fault_in          (fault_in),
    .local_3v3_en_out  (local_3v3_en_out),
    .local_2v5_en_out  (local_2v5_en_out),
    .wib_en_out        (wib_en_out),
    .wib_on_led_out    (wib_on_led_out),
    .fault_latched_out (fault_latched_out),
    .busy_out          (busy_out),
    .state_out         (state_out)
  );

  function automatic logic [17:0] ex(input logic [5:0] en, input logic v3, input logic v2,
                                     input logic [2:0] st, input logic b, input logic [5:0] fl);
    return {en, v3, v2, st, b, fl};
  endfunction

  function automatic logic [17:0] act18();
    return {wib_en_out, local_3v3_en_out, local_2v5_en_out, state_out, busy_out, fault_latched_out};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_axi);
    if (rst_n_in) blink_m++;
    #1;
  endtask

  task automatic issue(input logic [5:0] req, input logic [15:0] d);
    start_in  = 1'b1;
    en_req_in = req;
    dly_in    = d;
    tick();
    start_in  = 1'b0;
    en_req_in = '0;
  endtask

  task automatic run_cps(input string nm, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      while (c < cps[i].cyc) begin
        tick();
        c++;
      end
      chk($sformatf("%s@%0d", nm, c), {14'b0, act18()}, {14'b0, cps[i].exp});
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("reset_outs", {8'b0, act18(), wib_on_led_out}, 32'b0);
    rst_n_in = 1'b1;
    blink_m  = 0;
    tick();
    chk("post_release_idle", {8'b0, act18(), wib_on_led_out}, 32'b0);

    // dly_in=0: one step per cycle, start ignored in UP_CH/ON, fault on disabled channel ignored
    vt[0]  = '{1'b1, 6'b000011, 6'b0,      ex(6'b000000, 1'b1, 1'b0, ST_UP_3V3, 1'b1, 6'b0), 6'b000000};
    vt[1]  = '{1'b0, 6'b000000, 6'b0,      ex(6'b000000, 1'b1, 1'b1, ST_UP_2V5, 1'b1, 6'b0), 6'b000000};
    vt[2]  = '{1'b0, 6'b000000, 6'b0,      ex(6'b000001, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0), 6'b000001};
    vt[3]  = '{1'b1, 6'b111111, 6'b0,      ex(6'b000011, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0), 6'b000011};
    vt[4]  = '{1'b0, 6'b000000, 6'b000100, ex(6'b000011, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0), 6'b000011};
    vt[5]  = '{1'b1, 6'b111111, 6'b0,      ex(6'b000011, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0), 6'b000011};
    vt[6]  = '{1'b1, 6'b000000, 6'b0,      ex(6'b000011, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0), 6'b000011};
    vt[7]  = '{1'b0, 6'b000000, 6'b0,      ex(6'b000001, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0), 6'b000001};
    vt[8]  = '{1'b0, 6'b000000, 6'b0,      ex(6'b000000, 1'b1, 1'b1, ST_DN_2V5, 1'b1, 6'b0), 6'b000000};
    vt[9]  = '{1'b0, 6'b000000, 6'b0,      ex(6'b000000, 1'b1, 1'b0, ST_DN_3V3, 1'b1, 6'b0), 6'b000000};
    vt[10] = '{1'b0, 6'b000000, 6'b0,      ex(6'b000000, 1'b0, 1'b0, ST_IDLE,   1'b0, 6'b0), 6'b000000};
    vt[11] = '{1'b1, 6'b000000, 6'b0,      ex(6'b000000, 1'b0, 1'b0, ST_IDLE,   1'b0, 6'b0), 6'b000000};
    dly_in = '0;
    for (int i = 0; i < 12; i++) begin
      start_in  = vt[i].start;
      en_req_in = vt[i].req;
      fault_in  = vt[i].flt;
      tick();
      chk($sformatf("vec%0d", i), {8'b0, act18(), wib_on_led_out}, {8'b0, vt[i].exp, vt[i].led});
    end
    start_in = 1'b0; en_req_in = '0; fault_in = '0;

    // power-up, dly=4, mask 101101
    issue(6'b101101, 16'd4);
    cps[0] = '{0,  ex(6'b000000, 1'b1, 1'b0, ST_UP_3V3, 1'b1, 6'b0)};
    cps[1] = '{3,  ex(6'b000000, 1'b1, 1'b0, ST_UP_3V3, 1'b1, 6'b0)};
    cps[2] = '{4,  ex(6'b000000, 1'b1, 1'b1, ST_UP_2V5, 1'b1, 6'b0)};
    cps[3] = '{7,  ex(6'b000000, 1'b1, 1'b1, ST_UP_2V5, 1'b1, 6'b0)};
    cps[4] = '{8,  ex(6'b000001, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0)};
    cps[5] = '{12, ex(6'b000101, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0)};
    cps[6] = '{16, ex(6'b001101, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0)};
    cps[7] = '{19, ex(6'b001101, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0)};
    cps[8] = '{20, ex(6'b101101, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0)};
    run_cps("pwr_up", 9);

    // power-down, dly=3
    issue(6'b000000, 16'd3);
    cps[0] = '{0,  ex(6'b101101, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0)};
    cps[1] = '{2,  ex(6'b101101, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0)};
    cps[2] = '{3,  ex(6'b001101, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0)};
    cps[3] = '{6,  ex(6'b000101, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0)};
    cps[4] = '{9,  ex(6'b000001, 1'b1, 1'b1, ST_DN_CH,  1'b1, 6'b0)};
    cps[5] = '{12, ex(6'b000000, 1'b1, 1'b1, ST_DN_2V5, 1'b1, 6'b0)};
    cps[6] = '{14, ex(6'b000000, 1'b1, 1'b1, ST_DN_2V5, 1'b1, 6'b0)};
    cps[7] = '{15, ex(6'b000000, 1'b1, 1'b0, ST_DN_3V3, 1'b1, 6'b0)};
    cps[8] = '{17, ex(6'b000000, 1'b1, 1'b0, ST_DN_3V3, 1'b1, 6'b0)};
    cps[9] = '{18, ex(6'b000000, 1'b0, 1'b0, ST_IDLE,   1'b0, 6'b0)};
    run_cps("pwr_dn", 10);

    // fault on ch2 with all channels on
    issue(6'b111111, 16'd1);
    cps[0] = '{0, ex(6'b000000, 1'b1, 1'b0, ST_UP_3V3, 1'b1, 6'b0)};
    cps[1] = '{1, ex(6'b000000, 1'b1, 1'b1, ST_UP_2V5, 1'b1, 6'b0)};
    cps[2] = '{2, ex(6'b000001, 1'b1, 1'b1, ST_UP_CH,  1'b1, 6'b0)};
    cps[3] = '{7, ex(6'b111111, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0)};
    run_cps("flt_up", 4);
    dly_in   = 16'd2;
    fault_in = 6'b000100;
    tick();
    fault_in = '0;
    chk("flt_entry", {14'b0, act18()}, {14'b0, ex(6'b111011, 1'b1, 1'b1, ST_DN_CH, 1'b1, 6'b000100)});
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("led2_blink%0d", i), {31'b0, wib_on_led_out[2]}, {31'b0, blink_m[3]});
    end
    chk("flt_shutdown", {14'b0, act18()}, {14'b0, ex(6'b0, 1'b0, 1'b0, ST_IDLE, 1'b0, 6'b000100)});
    issue(6'b000000, 16'd1);
    chk("flt_clear", {8'b0, act18(), wib_on_led_out}, 32'b0);

    // async reset during UP_CH with three channels on
    issue(6'b001111, 16'd2);
    cps[0] = '{9, ex(6'b000111, 1'b1, 1'b1, ST_UP_CH, 1'b1, 6'b0)};
    run_cps("rst_pre", 1);
    #2 rst_n_in = 1'b0;
    #1 chk("rst_async", {8'b0, act18(), wib_on_led_out}, 32'b0);
    tick();
    tick();
    rst_n_in = 1'b1;
    blink_m  = 0;
    issue(6'b000001, 16'd1);
    cps[0] = '{0, ex(6'b000000, 1'b1, 1'b0, ST_UP_3V3, 1'b1, 6'b0)};
    cps[1] = '{1, ex(6'b000000, 1'b1, 1'b1, ST_UP_2V5, 1'b1, 6'b0)};
    cps[2] = '{2, ex(6'b000001, 1'b1, 1'b1, ST_ON,     1'b0, 6'b0)};
    run_cps("rst_after", 3);
    chk("rst_after_led", {26'b0, wib_on_led_out}, 32'h1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
